// File: rtl/bin_to_bcd_seq_if.sv
// Handshake and result bundle for the sequential binary-to-BCD converter.
// The master side requests conversions; the slave side is the converter.
interface bin_to_bcd_seq_if #(
  parameter int WIDTH      = 8,
  parameter int NUM_DIGITS = 3
);
  logic                    start;
  logic [WIDTH-1:0]        bin_in;
  logic                    blank_lz;
  logic                    busy;
  logic                    done;
  logic                    ovf;
  logic [4*NUM_DIGITS-1:0] bcd_out;
  logic [7*NUM_DIGITS-1:0] seg_out;

  modport master (
    output start, bin_in, blank_lz,
    input  busy, done, ovf, bcd_out, seg_out
  );

  modport slave (
    input  start, bin_in, blank_lz,
    output busy, done, ovf, bcd_out, seg_out
  );
endinterface

// File: rtl/bin_to_bcd_seq.sv
// Sequential binary-to-BCD converter (double-dabble, one bit per clock)
// with registered BCD, overflow flag and seven-segment outputs.
// Overflowed values show '-' on every digit; optional leading-zero blanking.
module bin_to_bcd_seq #(
  parameter int WIDTH          = 8,
  parameter int NUM_DIGITS     = 3,
  parameter bit SEG_ACTIVE_LOW = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  bin_to_bcd_seq_if.slave  bus
);

  // Scratch field: one nibble per digit plus a carry-out bit on top.
  localparam int SW = 4 * NUM_DIGITS + 1;
  localparam int RW = SW + WIDTH;
  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  function automatic logic [63:0] pow10(input int n);
    logic [63:0] r;
    r = 64'd1;
    for (int i = 0; i < n; i++) r = r * 64'd10;
    return r;
  endfunction

  localparam logic [63:0] LIMIT   = pow10(NUM_DIGITS);
  localparam logic [63:0] MAX_IN  = (64'd1 << WIDTH) - 64'd1;
  // Narrow inputs can never reach 10^NUM_DIGITS; the flag then folds to 0.
  localparam bit          CAN_OVF = (MAX_IN >= LIMIT);

  // Active-high glyphs, bit0 = a ... bit6 = g.
  localparam logic [6:0] GLYPH_BLANK = 7'b0000000;
  localparam logic [6:0] GLYPH_DASH  = 7'b1000000;

  typedef enum logic [1:0] {
    S_IDLE,
    S_CONV,
    S_DONE
  } state_t;

  function automatic logic [6:0] seg_font(input logic [3:0] nib);
    case (nib)
      4'd0:    seg_font = 7'b0111111;
      4'd1:    seg_font = 7'b0000110;
      4'd2:    seg_font = 7'b1011011;
      4'd3:    seg_font = 7'b1001111;
      4'd4:    seg_font = 7'b1100110;
      4'd5:    seg_font = 7'b1101101;
      4'd6:    seg_font = 7'b1111101;
      4'd7:    seg_font = 7'b0000111;
      4'd8:    seg_font = 7'b1111111;
      4'd9:    seg_font = 7'b1101111;
      default: seg_font = GLYPH_DASH;
    endcase
  endfunction

  // Apply the board's drive polarity to an active-high glyph.
  function automatic logic [6:0] seg_pol(input logic [6:0] s);
    return SEG_ACTIVE_LOW ? ~s : s;
  endfunction

  localparam logic [6:0] SEG_OFF = SEG_ACTIVE_LOW ? 7'h7F : 7'h00;

  state_t                  state;
  logic [CW-1:0]           cnt;
  logic [RW-1:0]           sr;
  logic                    ovf_cap;
  logic                    blz_cap;
  logic                    busy_q;
  logic                    done_q;
  logic                    ovf_q;
  logic [4*NUM_DIGITS-1:0] bcd_q;
  logic [7*NUM_DIGITS-1:0] seg_q;

  logic                    ovf_in;
  logic [RW-1:0]           adj;
  logic [RW-1:0]           shifted;
  logic [4*NUM_DIGITS-1:0] digits;
  logic                    carry;
  logic                    ovf_next;
  logic [4*NUM_DIGITS-1:0] bcd_next;
  logic [7*NUM_DIGITS-1:0] seg_next;
  logic                    seen;
  logic [3:0]              nib;

  assign ovf_in = CAN_OVF && (64'(bus.bin_in) >= LIMIT);

  // One double-dabble step: +3 on every scratch nibble >= 5, then shift left.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path
    // leaves it unassigned, which would otherwise infer a latch.
    adj = sr;
    for (int d = 0; d < NUM_DIGITS; d++) begin
      if (adj[WIDTH+4*d +: 4] >= 4'd5)
        adj[WIDTH+4*d +: 4] = adj[WIDTH+4*d +: 4] + 4'd3;
    end
    shifted = adj << 1;
  end

  assign digits = shifted[WIDTH +: 4*NUM_DIGITS];
  assign carry  = shifted[RW-1];

  // Final-result formatting: overflow dashes, leading-zero blanking, glyphs.
  always_comb begin
    ovf_next = ovf_cap | carry;
    bcd_next = ovf_next ? '1 : digits;
    seg_next = '0;
    seen     = 1'b0;
    nib      = '0;
    for (int d = NUM_DIGITS - 1; d >= 0; d--) begin
      nib  = digits[4*d +: 4];
      seen = seen | (nib != 4'd0);
      if (ovf_next)
        seg_next[7*d +: 7] = seg_pol(GLYPH_DASH);
      else if (blz_cap && !seen && (d != 0))
        seg_next[7*d +: 7] = seg_pol(GLYPH_BLANK);
      else
        seg_next[7*d +: 7] = seg_pol(seg_font(nib));
    end
  end

  // Control FSM with registered handshake and result outputs.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    if (rst) begin
      state   <= S_IDLE;
      cnt     <= '0;
      sr      <= '0;
      ovf_cap <= 1'b0;
      blz_cap <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      ovf_q   <= 1'b0;
      bcd_q   <= '0;
      seg_q   <= {NUM_DIGITS{SEG_OFF}};
    end else begin
      done_q <= 1'b0;
      case (state)
        S_IDLE: begin
          if (bus.start) begin
            sr      <= {{SW{1'b0}}, bus.bin_in};
            ovf_cap <= ovf_in;
            blz_cap <= bus.blank_lz;
            cnt     <= CW'(WIDTH - 1);
            busy_q  <= 1'b1;
            state   <= S_CONV;
          end
        end
        S_CONV: begin
          sr <= shifted;
          if (cnt == '0) begin
            busy_q <= 1'b0;
            done_q <= 1'b1;
            ovf_q  <= ovf_next;
            bcd_q  <= bcd_next;
            seg_q  <= seg_next;
            state  <= S_DONE;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        S_DONE:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

  assign bus.busy    = busy_q;
  assign bus.done    = done_q;
  assign bus.ovf     = ovf_q;
  assign bus.bcd_out = bcd_q;
  assign bus.seg_out = seg_q;

endmodule

// File: tb/tb_bin_to_bcd_seq.sv
// Self-checking bench for bin_to_bcd_seq: a default 8-bit/3-digit instance
// and a 4-bit/1-digit instance that can overflow, both active-low segments.
module tb_bin_to_bcd_seq;

  logic clk = 1'b0;
  logic rst = 1'b1;

  always #5 clk = ~clk;

  bin_to_bcd_seq_if #(.WIDTH(8), .NUM_DIGITS(3)) bus_a ();
  bin_to_bcd_seq_if #(.WIDTH(4), .NUM_DIGITS(1)) bus_b ();

  bin_to_bcd_seq #(.WIDTH(8), .NUM_DIGITS(3), .SEG_ACTIVE_LOW(1'b1)) dut_a (
    .clk (clk),
    .rst (rst),
    .bus (bus_a)
  );

  bin_to_bcd_seq #(.WIDTH(4), .NUM_DIGITS(1), .SEG_ACTIVE_LOW(1'b1)) dut_b (
    .clk (clk),
    .rst (rst),
    .bus (bus_b)
  );

  int n_cmp = 0;
  int n_bad = 0;

  // Active-high glyph table, g..a, for digits 0..9.
  logic [6:0] seg_tab [0:9] = '{7'b0111111, 7'b0000110, 7'b1011011, 7'b1001111,
                                7'b1100110, 7'b1101101, 7'b1111101, 7'b0000111,
                                7'b1111111, 7'b1101111};

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic int p10(input int n);
    int r = 1;
    for (int i = 0; i < n; i++) r = r * 10;
    return r;
  endfunction

  function automatic int dig(input int v, input int i);
    return (v / p10(i)) % 10;
  endfunction

  function automatic logic [63:0] model_bcd(input int v, input int nd);
    logic [63:0] r = '0;
    for (int i = 0; i < nd; i++)
      r[4*i +: 4] = (v >= p10(nd)) ? 4'hF : 4'(dig(v, i));
    return r;
  endfunction

  // Active-low expected segments: dashes on overflow, blanks above the
  // most-significant nonzero digit when blanking is requested.
  function automatic logic [63:0] model_seg(input int v, input bit blz, input int nd);
    logic [63:0] r = '0;
    logic [6:0]  s;
    int          msd = 0;
    for (int i = 0; i < nd; i++)
      if (dig(v, i) != 0) msd = i;
    for (int i = 0; i < nd; i++) begin
      if (v >= p10(nd))        s = 7'b1000000;
      else if (blz && i > msd) s = 7'b0000000;
      else                     s = seg_tab[dig(v, i)];
      r[7*i +: 7] = ~s;
    end
    return r;
  endfunction

  task automatic run_a(input int v, input bit blz);
    int cyc = 0;
    int busy_cnt = 0;
    @(negedge clk);
    bus_a.start    = 1'b1;
    bus_a.bin_in   = 8'(v);
    bus_a.blank_lz = blz;
    @(posedge clk); #1;
    bus_a.start = 1'b0;
    while (bus_a.done !== 1'b1 && cyc < 40) begin
      if (bus_a.busy === 1'b1) busy_cnt++;
      @(posedge clk); #1;
      cyc++;
    end
    check($sformatf("a_latency v=%0d", v), 64'(cyc), 64'd8);
    check($sformatf("a_busy_cycles v=%0d", v), 64'(busy_cnt), 64'd8);
    check("a_busy_in_done", 64'(bus_a.busy), 64'd0);
    check($sformatf("a_bcd v=%0d", v), 64'(bus_a.bcd_out), model_bcd(v, 3));
    check($sformatf("a_seg v=%0d blz=%0d", v, blz), 64'(bus_a.seg_out), model_seg(v, blz, 3));
    check($sformatf("a_ovf v=%0d", v), 64'(bus_a.ovf), 64'(v >= 1000));
    @(posedge clk); #1;
    check("a_done_one_cycle", 64'(bus_a.done), 64'd0);
  endtask

  task automatic run_b(input int v, input bit blz);
    int cyc = 0;
    @(negedge clk);
    bus_b.start    = 1'b1;
    bus_b.bin_in   = 4'(v);
    bus_b.blank_lz = blz;
    @(posedge clk); #1;
    bus_b.start = 1'b0;
    while (bus_b.done !== 1'b1 && cyc < 20) begin
      @(posedge clk); #1;
      cyc++;
    end
    check($sformatf("b_latency v=%0d", v), 64'(cyc), 64'd4);
    check($sformatf("b_bcd v=%0d", v), 64'(bus_b.bcd_out), model_bcd(v, 1));
    check($sformatf("b_seg v=%0d", v), 64'(bus_b.seg_out), model_seg(v, blz, 1));
    check($sformatf("b_ovf v=%0d", v), 64'(bus_b.ovf), 64'(v >= 10));
    @(posedge clk); #1;
  endtask

  initial begin
    int cyc;
    int cnt;
    int last;
    int pulses;
    int unstable;

    bus_a.start = 1'b0; bus_a.bin_in = '0; bus_a.blank_lz = 1'b0;
    bus_b.start = 1'b0; bus_b.bin_in = '0; bus_b.blank_lz = 1'b0;

    // Reset state.
    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", 64'(bus_a.busy), 64'd0);
    check("rst_done", 64'(bus_a.done), 64'd0);
    check("rst_ovf",  64'(bus_a.ovf),  64'd0);
    check("rst_bcd",  64'(bus_a.bcd_out), 64'd0);
    check("rst_seg",  64'(bus_a.seg_out), 64'h1FFFFF);
    check("rst_seg_b", 64'(bus_b.seg_out), 64'h7F);
    @(negedge clk);
    rst = 1'b0;

    // Small instance: overflow, recovery, digit 0 never blanked.
    run_b(15, 1'b0);
    run_b(7, 1'b0);
    run_b(0, 1'b1);
    run_b(12, 1'b1);
    for (int k = 0; k < 6; k++) run_b(int'($urandom_range(15)), 1'($urandom_range(1)));

    // Default instance: directed points.
    run_a(255, 1'b0);
    run_a(0, 1'b1);
    run_a(0, 1'b0);
    run_a(9, 1'b1);
    run_a(100, 1'b1);
    run_a(10, 1'b1);
    for (int k = 0; k < 20; k++) run_a(int'($urandom_range(255)), 1'($urandom_range(1)));

    // Start during CONV is ignored.
    @(negedge clk);
    bus_a.start = 1'b1; bus_a.bin_in = 8'd200; bus_a.blank_lz = 1'b0;
    @(posedge clk); #1;                       // edge 0
    bus_a.start = 1'b0;
    @(posedge clk);                           // edge 1
    @(posedge clk);                           // edge 2
    @(negedge clk);
    bus_a.start = 1'b1; bus_a.bin_in = 8'd17;
    @(posedge clk); #1;                       // edge 3
    bus_a.start = 1'b0;
    cyc = 3;
    while (bus_a.done !== 1'b1 && cyc < 40) begin
      @(posedge clk); #1;
      cyc++;
    end
    check("ign_latency", 64'(cyc), 64'd8);
    check("ign_bcd", 64'(bus_a.bcd_out), 64'h200);
    cnt = 0;
    repeat (12) begin
      @(posedge clk); #1;
      if (bus_a.busy === 1'b1 || bus_a.done === 1'b1) cnt++;
    end
    check("ign_no_requeue", 64'(cnt), 64'd0);

    // Reset in the middle of a conversion.
    @(negedge clk);
    bus_a.start = 1'b1; bus_a.bin_in = 8'd200;
    @(posedge clk); #1;                       // edge 0
    bus_a.start = 1'b0;
    repeat (4) @(posedge clk);                // edges 1..4
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;                       // edge 5
    check("mid_rst_busy", 64'(bus_a.busy), 64'd0);
    check("mid_rst_done", 64'(bus_a.done), 64'd0);
    check("mid_rst_ovf",  64'(bus_a.ovf),  64'd0);
    check("mid_rst_bcd",  64'(bus_a.bcd_out), 64'd0);
    check("mid_rst_seg",  64'(bus_a.seg_out), 64'h1FFFFF);
    @(negedge clk);
    rst = 1'b0;
    cnt = 0;
    repeat (15) begin
      @(posedge clk); #1;
      if (bus_a.done === 1'b1) cnt++;
    end
    check("mid_rst_no_done", 64'(cnt), 64'd0);

    // Back-to-back with start held high.
    @(negedge clk);
    bus_a.start = 1'b1; bus_a.bin_in = 8'd42; bus_a.blank_lz = 1'b0;
    cyc = 0;
    while (bus_a.done !== 1'b1 && cyc < 30) begin
      @(posedge clk); #1;
      cyc++;
    end
    check("b2b_first_done", 64'(bus_a.done), 64'd1);
    last = 0; pulses = 0; unstable = 0;
    for (int k = 1; k <= 35; k++) begin
      @(posedge clk); #1;
      if (bus_a.bcd_out !== 12'h042) unstable++;
      if (bus_a.done === 1'b1) begin
        check("b2b_gap", 64'(k - last), 64'd10);
        last = k;
        pulses++;
      end
    end
    check("b2b_pulses", 64'(pulses), 64'd3);
    check("b2b_stable", 64'(unstable), 64'd0);
    check("b2b_seg", 64'(bus_a.seg_out), model_seg(42, 1'b0, 3));
    @(negedge clk);
    bus_a.start = 1'b0;
    repeat (15) @(posedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
